// File: rtl/sram_like_slave.sv
// Single-outstanding sram-like bus responder with a fixed LATENCY and a word-organised local memory.
// state  | meaning
// S_IDLE | addr_ok high, waiting for a request
// S_WAIT | request latched, counter running down
// S_RESP | data_ok pulse; writes commit on the edge leaving this state
module sram_like_slave #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("sram_like_slave: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [3:0]          be;
  logic                misaligned;
  logic                mem_we;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

  // Upper address bits are deliberately ignored so addresses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign idx_q = addr_q[ADDR_W+1:2];

  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size_q)
      2'd0: be = 4'b0001 << addr_q[1:0];
      2'd1: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_q[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = |addr_q[1:0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          addr_d  = addr[ADDR_W+1:0];
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = S_RESP;
            rdata_d = mem_q[addr[ADDR_W+1:2]];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          rdata_d = mem_q[idx_q];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = wr_q & ~misaligned;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset drops any in-flight transaction, including one in its RESP cycle.
    if (rst) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      wr_d    = 1'b0;
      size_d  = 2'd0;
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    wr_q    <= wr_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign addr_ok = ~rst && (state_q == S_IDLE);
  assign data_ok = ~rst && (state_q == S_RESP);
  assign rdata   = rst ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: three instances at LATENCY 2, 1 and 4 share one clock and reset.
module tb_sram_like_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [1:0]  size  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  addr_ok;
  logic [2:0]  data_ok;
  logic [31:0] rdata [3];

  int tests = 0;
  int fails = 0;
  int lat_of [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  sram_like_slave #(.ADDR_W(8), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));
  sram_like_slave #(.ADDR_W(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));
  sram_like_slave #(.ADDR_W(8), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .req(req[2]), .wr(wr[2]), .size(size[2]), .addr(addr[2]),
    .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

  typedef struct {
    int        d;
    bit        w;
    bit [1:0]  sz;
    bit [31:0] a;
    bit [31:0] wd;
    bit        ck;
    bit [31:0] ex;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on instance d; returns on the negedge of its data_ok cycle.
  task automatic do_txn(input int d, input bit w, input bit [1:0] sz, input bit [31:0] a,
                        input bit [31:0] wd, input bit ck, input bit [31:0] ex);
    int n;
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    chk("idle_addr_ok", 32'(addr_ok[d]), 32'd1);
    chk("idle_data_ok", 32'(data_ok[d]), 32'd0);
    chk("idle_rdata", rdata[d], 32'd0);
    @(negedge clk);
    req[d] = 1'b0;
    n = 1;
    while (!data_ok[d] && n < 20) begin
      chk("busy_addr_ok", 32'(addr_ok[d]), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of[d]));
    chk("resp_addr_ok", 32'(addr_ok[d]), 32'd0);
    if (ck) chk("rdata", rdata[d], ex);
  endtask

  initial begin
    logic [31:0] b2b_a [4];
    logic [31:0] b2b_e [4];
    bit seen;

    rst = 1'b1;
    req = '0; wr = '0;
    for (int i = 0; i < 3; i++) begin
      size[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
    end

    // name: d, w, sz, a, wd, ck, ex
    vt.push_back('{0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 2'd2, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF});
    vt.push_back('{0, 1'b1, 2'd2, 32'h20, 32'h0,        1'b0, 32'h0});
    vt.push_back('{0, 1'b1, 2'd0, 32'h21, 32'h0000AA00, 1'b0, 32'h0});
    vt.push_back('{0, 1'b1, 2'd1, 32'h22, 32'h12340000, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 2'd2, 32'h20, 32'h0,        1'b1, 32'h1234AA00});
    vt.push_back('{0, 1'b1, 2'd1, 32'h23, 32'hFFFFFFFF, 1'b1, 32'h1234AA00});
    vt.push_back('{0, 1'b0, 2'd0, 32'h20, 32'h0,        1'b1, 32'h1234AA00});
    vt.push_back('{0, 1'b1, 2'd2, 32'h30, 32'h11111111, 1'b0, 32'h0});
    vt.push_back('{0, 1'b1, 2'd2, 32'h31, 32'hFFFFFFFF, 1'b1, 32'h11111111});
    vt.push_back('{0, 1'b0, 2'd2, 32'h30, 32'h0,        1'b1, 32'h11111111});
    vt.push_back('{0, 1'b1, 2'd3, 32'h60, 32'hA5A5A5A5, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 2'd2, 32'h60, 32'h0,        1'b1, 32'hA5A5A5A5});
    vt.push_back('{0, 1'b1, 2'd0, 32'h63, 32'h5A000000, 1'b0, 32'h0});
    vt.push_back('{0, 1'b0, 2'd2, 32'h60, 32'h0,        1'b1, 32'h5AA5A5A5});
    vt.push_back('{0, 1'b1, 2'd2, 32'h50, 32'h0,        1'b0, 32'h0});
    vt.push_back('{0, 1'b1, 2'd2, 32'h50, 32'hCAFEF00D, 1'b1, 32'h00000000});
    vt.push_back('{0, 1'b0, 2'd2, 32'h50, 32'h0,        1'b1, 32'hCAFEF00D});
    vt.push_back('{1, 1'b1, 2'd2, 32'h000, 32'h0BADF00D, 1'b0, 32'h0});
    vt.push_back('{1, 1'b1, 2'd2, 32'h004, 32'h44444444, 1'b0, 32'h0});
    vt.push_back('{1, 1'b1, 2'd2, 32'h008, 32'h88888888, 1'b0, 32'h0});
    vt.push_back('{2, 1'b1, 2'd2, 32'h40, 32'h12345678, 1'b0, 32'h0});
    vt.push_back('{2, 1'b0, 2'd2, 32'h40, 32'h0,         1'b1, 32'h12345678});

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_addr_ok", 32'(addr_ok[i]), 32'd0);
      chk("rst_data_ok", 32'(data_ok[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_addr_ok", 32'(addr_ok[i]), 32'd1);
      chk("post_rst_data_ok", 32'(data_ok[i]), 32'd0);
    end

    foreach (vt[i]) do_txn(vt[i].d, vt[i].w, vt[i].sz, vt[i].a, vt[i].wd, vt[i].ck, vt[i].ex);

    // LATENCY=1 with req held high: accept every other cycle, 0x400 aliases 0x000.
    b2b_a = '{32'h000, 32'h004, 32'h400, 32'h008};
    b2b_e = '{32'h0BADF00D, 32'h44444444, 32'h0BADF00D, 32'h88888888};
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = b2b_a[0];
    for (int i = 0; i < 4; i++) begin
      chk("b2b_addr_ok", 32'(addr_ok[1]), 32'd1);
      chk("b2b_idle_data_ok", 32'(data_ok[1]), 32'd0);
      @(negedge clk);
      chk("b2b_data_ok", 32'(data_ok[1]), 32'd1);
      chk("b2b_resp_addr_ok", 32'(addr_ok[1]), 32'd0);
      chk("b2b_rdata", rdata[1], b2b_e[i]);
      if (i < 3) addr[1] = b2b_a[i+1];
      else req[1] = 1'b0;
      @(negedge clk);
    end

    // Reset two cycles into a LATENCY=4 write: dropped, memory untouched.
    req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'd2; addr[2] = 32'h40; wdata[2] = 32'h55;
    chk("rw_addr_ok", 32'(addr_ok[2]), 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_rst_data_ok", 32'(data_ok[2]), 32'd0);
    chk("rw_rst_addr_ok", 32'(addr_ok[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_after_addr_ok", 32'(addr_ok[2]), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (data_ok[2]) seen = 1'b1;
    end
    chk("rw_no_data_ok", 32'(seen), 32'd0);
    do_txn(2, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'h12345678);

    // Reset landing exactly on the RESP cycle: no pulse, no commit.
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'd2; addr[2] = 32'h40; wdata[2] = 32'h99;
    @(negedge clk);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr_data_ok", 32'(data_ok[2]), 32'd0);
    chk("rr_rdata", rdata[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_txn(2, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_like_slave.md
# sram_like_slave

Single-outstanding responder for the CPU's sram-like bus (req/addr_ok/data_ok). It holds a word-organised local memory and answers each accepted request after a fixed, parameterised latency. It sits opposite the CPU's instruction or data port in standalone benches and in the SoC as a fast scratch memory. It exercises the CPU pipeline's stall registers with deterministic wait states.

## Interface
- ADDR_W, 8, word-index bits; memory depth = 2^ADDR_W 32-bit words
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  1  master request valid
- wr  input  1  1 = write, 0 = read
- size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = treated as word
- addr  input  32  byte address
- wdata  input  32  write data, lane-aligned to the full word (byte k at bits 8k+7:8k)
- addr_ok  output  1  request accepted when req & addr_ok at a rising edge
- data_ok  output  1  one-cycle completion pulse
- rdata  output  32  read word, valid only while data_ok = 1

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - addr_ok = 1.
  - On req & addr_ok, latch wr, size, addr, wdata and load the counter with LATENCY-1.
  - Go to RESP if LATENCY = 1, else go to WAIT.
- WAIT:
  - addr_ok = 0.
  - The counter decrements every cycle.
  - On the edge where the counter is 1, go to RESP.
- RESP:
  - data_ok = 1 for exactly one cycle, then return to IDLE.
  - addr_ok = 0 in this cycle.
- Word index = addr[ADDR_W+1:2]. Address bits above ADDR_W+1 are ignored, so addresses alias modulo 4·2^ADDR_W.
- Byte enables from latched size and addr[1:0]:
  - byte: 1 << addr[1:0]
  - halfword: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1
  - word: 4'b1111
- Misaligned requests are halfword with addr[0] = 1, or word with addr[1:0] != 0. They write nothing but still complete normally with data_ok.
- Reads:
  - rdata = full 32-bit word at the index; the master extracts lanes.
  - The word is sampled on the edge entering RESP.
  - A read never returns data from a later write.
- Writes:
  - Enabled lanes commit on the edge that leaves RESP.
  - rdata during a write's data_ok cycle = old word contents before the commit.
- A req arriving while not in IDLE is ignored. The master must hold req until addr_ok.
- Memory contents are not cleared by rst and are undefined until written.

## Timing
- During rst and in the first cycle after rst deasserts:
  - state = IDLE, counter = 0
  - data_ok = 0, rdata = 0
  - addr_ok = 0 while rst = 1, and 1 from the first cycle with rst = 0
- Accept at edge T → data_ok high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Example, LATENCY = 2: accepted at edge T, WAIT in cycle T..T+1, data_ok = 1 in cycle T+1..T+2.
- addr_ok rises in the cycle after data_ok. Maximum throughput is one transaction per LATENCY+1 cycles.
- rdata returns to 0 in every cycle where data_ok = 0 (registered, cleared on leaving RESP).
- addr_ok and data_ok are never high in the same cycle.
- Reset mid-transaction (rst = 1 in WAIT or RESP):
  - Return to IDLE; the transaction is dropped.
  - No memory write occurs and no data_ok is produced, including when rst coincides with the RESP cycle.
- Counter width: 4 bits. LATENCY outside 1..15 is illegal; an elaboration-time check should flag it.

## Test plan
- Word write then read, LATENCY = 2:
  - Stimulus: write 0xDEADBEEF to addr 0x10, then read 0x10.
  - Required: data_ok exactly 2 cycles after each accept; read rdata = 0xDEADBEEF; addr_ok low from accept through data_ok.
- Byte and halfword writes:
  - Stimulus: word 0x00000000 at 0x20; byte 0xAA to 0x21 (wdata 0x0000AA00); half 0x1234 to 0x22 (wdata 0x12340000).
  - Required: read 0x20 → 0x1234AA00.
- Misaligned requests:
  - Stimulus: word write 0xFFFFFFFF to 0x31 after writing 0x11111111 to 0x30.
  - Required: data_ok still pulses once; read 0x30 → 0x11111111.
- LATENCY = 1 back-to-back:
  - Stimulus: req held high for 4 reads.
  - Required: accepts every 2 cycles; data_ok one cycle after each accept; aliasing check: addr 0x400 (ADDR_W = 8) reads the same word as 0x000.
- Reset in WAIT:
  - Stimulus: LATENCY = 4, start a write of 0x55 to 0x40, assert rst for 1 cycle two cycles after accept.
  - Required: no data_ok; addr_ok = 1 the cycle after rst deasserts; read 0x40 returns its prior value.
- Read-during-write ordering:
  - Stimulus: write 0xCAFEF00D to 0x50 (prior value 0x0), then immediately read 0x50.
  - Required: write's data_ok rdata = 0x00000000; read returns 0xCAFEF00D.
